// File: rtl/con_unit.sv
// Conditional-branch evaluation unit: captures a condition code and operand(s), holds the result in q.
// Optional two-operand signed compares (codes 6/7) built only when CON_UNIT_CMP_EN is defined.
module con_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IR_W     = 32,
    parameter int unsigned COND_LSB = 19,
    parameter int unsigned COND_W   = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IR_W-1:0]   ir,
    input  logic [DATA_W-1:0] bus,
    input  logic              con_in,
    output logic              q,
    output logic              q_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt
);

`ifdef CON_UNIT_CMP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd2, WAIT_B = 2'd1} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd2} state_t;
`endif

    state_t              state_q, state_d;
    logic [2:0]          cc_q, cc_d, cc_in;
    logic [DATA_W-1:0]   a_q, a_d;
`ifdef CON_UNIT_CMP_EN
    logic [DATA_W-1:0]   b_q, b_d;
`endif
    logic                q_q, q_d;
    logic                q_valid_q, q_valid_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
    logic                result;

    // Only the condition field of ir is consumed; the rest of the word is don't-care.
    logic unused_ir;
    assign unused_ir = ^ir;

    always_comb begin
        cc_in = '0;
        cc_in[COND_W-1:0] = ir[COND_LSB +: COND_W];

        result = 1'b0;
        case (cc_q)
            3'd0: result = (a_q == '0);
            3'd1: result = (a_q != '0);
            3'd2: result = ~a_q[DATA_W-1];
            3'd3: result = a_q[DATA_W-1];
            3'd4: result = 1'b1;
            3'd5: result = 1'b0;
`ifdef CON_UNIT_CMP_EN
            3'd6: result = ($signed(a_q) < $signed(b_q));
            3'd7: result = ($signed(a_q) >= $signed(b_q));
`endif
            default: result = 1'b0;
        endcase

        state_d     = state_q;
        cc_d        = cc_q;
        a_d         = a_q;
`ifdef CON_UNIT_CMP_EN
        b_d         = b_q;
`endif
        q_d         = q_q;
        q_valid_d   = 1'b0;
        taken_cnt_d = taken_cnt_q;

        case (state_q)
            IDLE: begin
                if (con_in) begin
                    cc_d    = cc_in;
                    a_d     = bus;
                    state_d = EVAL;
`ifdef CON_UNIT_CMP_EN
                    if (cc_in[2:1] == 2'b11) state_d = WAIT_B;
`endif
                end
            end
`ifdef CON_UNIT_CMP_EN
            WAIT_B: begin
                if (con_in) begin
                    b_d     = bus;
                    state_d = EVAL;
                end
            end
`endif
            EVAL: begin
                q_d       = result;
                q_valid_d = 1'b1;
                if (result && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cc_q        <= '0;
            a_q         <= '0;
`ifdef CON_UNIT_CMP_EN
            b_q         <= '0;
`endif
            q_q         <= 1'b0;
            q_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cc_q        <= cc_d;
            a_q         <= a_d;
`ifdef CON_UNIT_CMP_EN
            b_q         <= b_d;
`endif
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            busy_q      <= busy_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign busy      = busy_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_con_unit.sv
// Directed bench for con_unit: a 3-bit-code / 2-bit-counter instance and a default-parameter instance.
module tb_con_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = '0;
    logic [31:0] bus = '0;
    logic        con_drv = 1'b0;
    logic        sel = 1'b0;

    logic        con_a, con_b;
    logic        q_a, qv_a, busy_a;
    logic [1:0]  cnt_a;
    logic        q_b, qv_b, busy_b;
    logic [15:0] cnt_b;

    logic        q_m, qv_m, busy_m;
    logic [15:0] cnt_m;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    logic [15:0] model_a = '0;
    logic [15:0] model_b = '0;

    always #5 clk = ~clk;

    assign con_a  = con_drv & ~sel;
    assign con_b  = con_drv & sel;
    assign q_m    = sel ? q_b : q_a;
    assign qv_m   = sel ? qv_b : qv_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign cnt_m  = sel ? cnt_b : {14'd0, cnt_a};

    con_unit #(.DATA_W(32), .IR_W(32), .COND_LSB(19), .COND_W(3), .CNT_W(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ir(ir), .bus(bus), .con_in(con_a),
        .q(q_a), .q_valid(qv_a), .busy(busy_a), .taken_cnt(cnt_a)
    );

    con_unit u_dut_b (
        .clk(clk), .rst_n(rst_n), .ir(ir), .bus(bus), .con_in(con_b),
        .q(q_b), .q_valid(qv_b), .busy(busy_b), .taken_cnt(cnt_b)
    );

    typedef struct {
        logic [2:0]  cc;
        logic [31:0] a;
        logic [31:0] b;
        logic        ir31;
        logic        exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // One evaluation on the selected instance; checks the exact cycle timing of busy/q_valid.
    task automatic run_op(input logic [2:0] cc, input logic [31:0] a, input logic [31:0] b,
                          input logic ir31, input logic exp_q, input int unsigned gap,
                          input logic pulse);
        logic two;
        logic [15:0] exp_cnt;
        two = 1'b0;
`ifdef CON_UNIT_CMP_EN
        if (!sel && cc[2:1] == 2'b11) two = 1'b1;
`endif
        @(negedge clk);
        check("idle_qv", {31'd0, qv_m}, 32'd0);
        check("idle_busy", {31'd0, busy_m}, 32'd0);
        ir = '0;
        ir[21:19] = cc;
        ir[31] = ir31;
        ir[0] = ~ir31;
        bus = a;
        con_drv = 1'b1;
        if (two) begin
            for (int unsigned i = 0; i < gap; i++) begin
                @(negedge clk);
                check("wait_busy", {31'd0, busy_m}, 32'd1);
                check("wait_qv", {31'd0, qv_m}, 32'd0);
                con_drv = 1'b0;
                bus = $urandom;
                ir = $urandom;
            end
            @(negedge clk);
            check("wait_busy", {31'd0, busy_m}, 32'd1);
            bus = b;
            con_drv = 1'b1;
        end
        @(negedge clk);
        check("eval_busy", {31'd0, busy_m}, 32'd1);
        check("eval_qv", {31'd0, qv_m}, 32'd0);
        con_drv = pulse;
        bus = 32'h0;
        ir = $urandom;
        @(negedge clk);
        con_drv = 1'b0;
        if (sel) begin
            if (exp_q && model_b != 16'hFFFF) model_b = model_b + 16'd1;
            exp_cnt = model_b;
        end else begin
            if (exp_q && model_a != 16'd3) model_a = model_a + 16'd1;
            exp_cnt = model_a;
        end
        check("res_q", {31'd0, q_m}, {31'd0, exp_q});
        check("res_qv", {31'd0, qv_m}, 32'd1);
        check("res_busy", {31'd0, busy_m}, 32'd0);
        check("res_cnt", {16'd0, cnt_m}, {16'd0, exp_cnt});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_q"}, {31'd0, q_m}, 32'd0);
        check({tag, "_qv"}, {31'd0, qv_m}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_m}, 32'd0);
        check({tag, "_cnt"}, {16'd0, cnt_m}, 32'd0);
    endtask

    initial begin
        vecs.push_back('{3'd0, 32'h0000_0000, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{3'd0, 32'h0000_0001, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{3'd1, 32'h0000_0000, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{3'd1, 32'h0000_0080, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{3'd2, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{3'd5, 32'h0000_0000, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 32'h0000_0005, 32'h0, 1'b0, 1'b1});
`ifdef CON_UNIT_CMP_EN
        vecs.push_back('{3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1});
        vecs.push_back('{3'd7, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1});
        vecs.push_back('{3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{3'd6, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1});
`else
        vecs.push_back('{3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0});
`endif

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b0;
        check_reset_state("rst_a");
        sel = 1'b1;
        check_reset_state("rst_b");
        sel = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].cc, vecs[i].a, vecs[i].b, vecs[i].ir31, vecs[i].exp_q, 2, 1'b0);

        // Reset during EVAL: pending result discarded, no q_valid.
        run_op(3'd4, 32'h0, 32'h0, 1'b0, 1'b1, 2, 1'b0);
        @(negedge clk);
        ir = '0;
        ir[21:19] = 3'd5;
        con_drv = 1'b1;
        @(negedge clk);
        con_drv = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_a = '0;
        check_reset_state("rst_eval");
        @(negedge clk);
        check("rst_eval_noqv", {31'd0, qv_m}, 32'd0);

`ifdef CON_UNIT_CMP_EN
        // Reset while parked in WAIT_B.
        run_op(3'd4, 32'h0, 32'h0, 1'b0, 1'b1, 2, 1'b0);
        @(negedge clk);
        ir = '0;
        ir[21:19] = 3'd6;
        bus = 32'hFFFF_FFFF;
        con_drv = 1'b1;
        @(negedge clk);
        con_drv = 1'b0;
        check("waitb_busy", {31'd0, busy_m}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_a = '0;
        check_reset_state("rst_waitb");
        @(negedge clk);
        check("rst_waitb_noqv", {31'd0, qv_m}, 32'd0);
`endif
        run_op(3'd4, 32'h0, 32'h0, 1'b0, 1'b1, 2, 1'b0);

        // Saturating counter with con_in pulsed during EVAL.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_a = '0;
        check_reset_state("rst_cnt");
        for (int k = 0; k < 5; k++) begin
            run_op(3'd4, 32'h0, 32'h0, 1'b0, 1'b1, 2, 1'b1);
            case (k)
                0: check("cnt_seq", {16'd0, cnt_m}, 32'd1);
                1: check("cnt_seq", {16'd0, cnt_m}, 32'd2);
                default: check("cnt_seq", {16'd0, cnt_m}, 32'd3);
            endcase
        end

        // Default instance: 2-bit field, ir bit 21 must be ignored.
        sel = 1'b1;
        run_op(3'b100, 32'h0000_0005, 32'h0, 1'b0, 1'b0, 2, 1'b0);
        run_op(3'b100, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 2, 1'b0);
        run_op(3'b111, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 2, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 2, 1'b0);
        run_op(3'b101, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 2, 1'b0);
        sel = 1'b0;
        check("cnt_b_final", {16'd0, cnt_b}, 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
